// File: rtl/cache_controller_pkg.sv
// Shared definitions for the two-way read cache sitting in front of sram_controller.
// Holds the FSM state encoding, the data-memory base address and the address field positions.
package cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_LO = 2'd1,
        FILL_HI = 2'd2,
        WRITE   = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    localparam int unsigned OFFSET_BIT = 2;
    localparam int unsigned INDEX_LSB  = 3;
    localparam int unsigned TAG_LSB    = 9;

endpackage

// File: rtl/cache_controller_cache_array.sv
// Valid/tag/data/LRU storage for a two-way set-associative cache with two-word lines.
// Asynchronous lookup; line fill, word update and LRU update happen on the clock edge.
module cache_array #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 10,
    parameter int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_index,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_offset,
    output logic             o_hit,
    output logic [31:0]      o_rword,
    input  logic             i_fill_en,
    input  logic [63:0]      i_fill_line,
    input  logic             i_word_we,
    input  logic [31:0]      i_wdata,
    input  logic             i_lru_touch
);

    logic [SETS-1:0]  r_valid0, r_valid1, r_lru;
    logic [TAG_W-1:0] r_tag0  [SETS];
    logic [TAG_W-1:0] r_tag1  [SETS];
    logic [63:0]      r_data0 [SETS];
    logic [63:0]      r_data1 [SETS];

    logic        w_hit0, w_hit1, w_victim;
    logic [63:0] w_line;

    assign w_hit0  = r_valid0[i_index] && (r_tag0[i_index] == i_tag);
    assign w_hit1  = r_valid1[i_index] && (r_tag1[i_index] == i_tag);
    assign o_hit   = w_hit0 | w_hit1;
    assign w_line  = w_hit1 ? r_data1[i_index] : r_data0[i_index];
    assign o_rword = i_offset ? w_line[63:32] : w_line[31:0];

    // Fill empty ways first so the LRU bit only matters once the set is full.
    assign w_victim = !r_valid0[i_index] ? 1'b0 :
                      !r_valid1[i_index] ? 1'b1 : r_lru[i_index];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            if (i_fill_en) begin
                if (w_victim) r_valid1[i_index] <= 1'b1;
                else          r_valid0[i_index] <= 1'b1;
            end
            if (i_lru_touch && o_hit)
                r_lru[i_index] <= w_hit0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            if (w_victim) begin
                r_data1[i_index] <= i_fill_line;
                r_tag1[i_index]  <= i_tag;
            end else begin
                r_data0[i_index] <= i_fill_line;
                r_tag0[i_index]  <= i_tag;
            end
        end else if (i_word_we) begin
            if (w_hit1) begin
                if (i_offset) r_data1[i_index][63:32] <= i_wdata;
                else          r_data1[i_index][31:0]  <= i_wdata;
            end else if (w_hit0) begin
                if (i_offset) r_data0[i_index][63:32] <= i_wdata;
                else          r_data0[i_index][31:0]  <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate read cache between the MEM stage and sram_controller.
// Read hits complete with no stall; misses fetch a two-word line via two SRAM reads.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int unsigned SETS      = 64,
    parameter int unsigned TAG_W     = 10,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);

    state_t      r_state, w_next;
    logic        r_seen_busy;
    logic [31:0] r_word0;

    logic [31:0]      w_mem_addr;
    logic [IDX_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic             w_offset, w_hit, w_accept;
    logic             w_fill_en, w_word_we, w_lru_touch;
    logic [31:0]      w_rword;
    logic             w_unused;

    assign w_mem_addr = address - BASE_ADDR;
    assign w_index    = w_mem_addr[INDEX_LSB +: IDX_W];
    assign w_tag      = w_mem_addr[TAG_LSB +: TAG_W];
    assign w_offset   = w_mem_addr[OFFSET_BIT];
    assign w_unused   = ^{w_mem_addr[31:TAG_LSB+TAG_W], w_mem_addr[1:0]};
    assign sram_wdata = wdata;

    // sram_controller reports ready while idle, so a Done is only trusted
    // once this state has watched ready drop at least once.
    assign w_accept = sram_ready & r_seen_busy;

    cache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_index     (w_index),
        .i_tag       (w_tag),
        .i_offset    (w_offset),
        .o_hit       (w_hit),
        .o_rword     (w_rword),
        .i_fill_en   (w_fill_en),
        .i_fill_line ({sram_rdata, r_word0}),
        .i_word_we   (w_word_we),
        .i_wdata     (wdata),
        .i_lru_touch (w_lru_touch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seen_busy <= 1'b0;
            r_word0     <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_seen_busy <= 1'b0;
            else if (r_state != IDLE && !sram_ready)
                r_seen_busy <= 1'b1;
            if (r_state == FILL_LO && w_accept)
                r_word0 <= sram_rdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        ready        = 1'b0;
        rdata        = '0;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        sram_address = address;
        w_fill_en    = 1'b0;
        w_word_we    = 1'b0;
        w_lru_touch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_w_en) begin
                    w_next = WRITE;
                end else if (mem_r_en) begin
                    if (w_hit) begin
                        ready       = 1'b1;
                        rdata       = w_rword;
                        w_lru_touch = 1'b1;
                    end else begin
                        w_next = FILL_LO;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            FILL_LO: begin
                sram_r_en    = 1'b1;
                sram_address = {address[31:3], 3'b000};
                if (w_accept) w_next = FILL_HI;
            end
            FILL_HI: begin
                sram_r_en    = 1'b1;
                sram_address = {address[31:3], 3'b100};
                if (w_accept) begin
                    w_fill_en = 1'b1;
                    w_next    = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                if (w_accept) begin
                    ready       = 1'b1;
                    w_word_we   = w_hit;
                    w_lru_touch = w_hit;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a recency-list cache model and an SRAM model.
// The SRAM model reports ready while idle, so the controller's handshake masking is exercised.
`timescale 1ns/1ps
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata, rdata;
    logic        mem_r_en, mem_w_en, ready;
    logic [31:0] sram_address, sram_wdata, sram_rdata;
    logic        sram_r_en, sram_w_en, sram_ready;

    always #5 clk = ~clk;

    cache_controller #(
        .SETS      (64),
        .TAG_W     (10),
        .BASE_ADDR (32'd1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    // ---------------- SRAM device model ----------------
    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_alog[$];
    logic [31:0] wr_dlog[$];

    int          s_st, s_cnt;
    logic [31:0] s_addr, s_wd, s_rdata;
    logic        s_is_w;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    assign sram_ready = (s_st != 1);
    assign sram_rdata = s_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_st    <= 0;
            s_cnt   <= 0;
            s_rdata <= '0;
        end else begin
            case (s_st)
                0: if (sram_r_en || sram_w_en) begin
                    s_addr <= sram_address;
                    s_wd   <= sram_wdata;
                    s_is_w <= sram_w_en;
                    s_cnt  <= int'($urandom_range(1, 4));
                    s_st   <= 1;
                    if (sram_w_en) begin
                        wr_alog.push_back(sram_address);
                        wr_dlog.push_back(sram_wdata);
                    end else begin
                        rd_log.push_back(sram_address);
                    end
                end
                1: if (s_cnt <= 1) begin
                    s_st <= 2;
                    if (s_is_w) sram_mem[s_addr] = s_wd;
                    else        s_rdata <= sram_mem.exists(s_addr) ? sram_mem[s_addr] : dflt(s_addr);
                end else begin
                    s_cnt <= s_cnt - 1;
                end
                default: s_st <= 0;
            endcase
        end
    end

    // ---------------- cache reference model: per-set recency list ----------------
    typedef struct packed {
        logic [9:0]  tag;
        logic [31:0] w0;
        logic [31:0] w1;
    } line_t;

    line_t m_line [64][2];   // slot 0 = most recently used
    int    m_cnt  [64];

    function automatic int m_find(input int unsigned idx, input logic [9:0] tg);
        for (int s = 0; s < m_cnt[idx]; s++)
            if (m_line[idx][s].tag == tg) return s;
        return -1;
    endfunction

    task automatic m_touch(input int unsigned idx, input int slot);
        line_t t;
        if (slot == 1) begin
            t = m_line[idx][0];
            m_line[idx][0] = m_line[idx][1];
            m_line[idx][1] = t;
        end
    endtask

    task automatic m_insert(input int unsigned idx, input line_t ln);
        m_line[idx][1] = m_line[idx][0];
        m_line[idx][0] = ln;
        if (m_cnt[idx] < 2) m_cnt[idx]++;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endtask

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_alog.delete();
        wr_dlog.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_clear();
        clear_logs();
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] ma, base, exp_d;
        int unsigned idx;
        logic [9:0]  tg;
        int          slot, stall;
        line_t       ln;
        ma   = a - 32'd1024;
        idx  = (ma / 8) % 64;
        tg   = 10'((ma / 512) % 1024);
        base = a & ~32'h7;
        slot = m_find(idx, tg);
        clear_logs();
        @(posedge clk);
        #1;
        address  = a;
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        stall    = 0;
        @(negedge clk);
        while (!ready && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        check_eq("rd_ready", 32'(ready), 32'd1);
        check_eq("rd_hit", 32'(stall == 0), 32'(slot >= 0));
        check_eq("rd_fills", 32'(rd_log.size()), (slot >= 0) ? 32'd0 : 32'd2);
        check_eq("rd_no_write", 32'(wr_alog.size()), 32'd0);
        if (slot < 0) begin
            if (rd_log.size() == 2) begin
                check_eq("fill_lo_addr", rd_log[0], base);
                check_eq("fill_hi_addr", rd_log[1], base + 32'd4);
            end
            ln.tag = tg;
            ln.w0  = ref_rd(base);
            ln.w1  = ref_rd(base + 32'd4);
            m_insert(idx, ln);
        end else begin
            m_touch(idx, slot);
        end
        ln    = m_line[idx][0];
        exp_d = a[2] ? ln.w1 : ln.w0;
        check_eq("rd_data", rdata, exp_d);
        @(posedge clk);
        #1 mem_r_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        logic [31:0] ma;
        int unsigned idx;
        logic [9:0]  tg;
        int          slot, stall;
        ma   = a - 32'd1024;
        idx  = (ma / 8) % 64;
        tg   = 10'((ma / 512) % 1024);
        slot = m_find(idx, tg);
        clear_logs();
        @(posedge clk);
        #1;
        address  = a;
        wdata    = d;
        mem_w_en = 1'b1;
        mem_r_en = both;
        stall    = 0;
        @(negedge clk);
        while (!ready && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        check_eq("wr_ready", 32'(ready), 32'd1);
        check_eq("wr_stalled", 32'(stall > 0), 32'd1);
        check_eq("wr_count", 32'(wr_alog.size()), 32'd1);
        check_eq("wr_no_read", 32'(rd_log.size()), 32'd0);
        if (wr_alog.size() == 1) begin
            check_eq("wr_addr", wr_alog[0], a);
            check_eq("wr_data", wr_dlog[0], d);
        end
        ref_mem[a] = d;
        if (slot >= 0) begin
            if (a[2]) m_line[idx][slot].w1 = d;
            else      m_line[idx][slot].w0 = d;
            m_touch(idx, slot);
        end
        @(posedge clk);
        #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] ma;
        int unsigned sel, idx;
        sel = $urandom_range(0, 2);
        idx = (sel == 0) ? 0 : (sel == 1) ? 1 : 63;
        ma  = ($urandom_range(0, 2) * 512) + (idx * 8) + ($urandom_range(0, 1) * 4);
        if ($urandom_range(0, 9) == 0) ma = ma + 32'h80000;
        return ma + 32'd1024;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int unsigned r;
        address  = '0;
        wdata    = '0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        m_clear();
        do_reset();

        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_sram_r_en", 32'(sram_r_en), 32'd0);
        check_eq("rst_sram_w_en", 32'(sram_w_en), 32'd0);

        sram_mem[32'd1024] = 32'h11111111;
        sram_mem[32'd1028] = 32'h22222222;
        ref_mem[32'd1024]  = 32'h11111111;
        ref_mem[32'd1028]  = 32'h22222222;

        do_read(32'd1024);
        do_read(32'd1028);
        do_read(32'd1536);
        do_read(32'd2048);
        do_read(32'd1536);
        do_read(32'd1024);
        do_write(32'd1028, 32'hDEADBEEF, 1'b0);
        do_read(32'd1028);
        check_eq("deadbeef", rdata, 32'hDEADBEEF);
        do_write(32'd4096, 32'h0BADF00D, 1'b0);
        do_read(32'd4096);

        // Reset while the second line-fill transaction is in flight.
        do_reset();
        @(posedge clk);
        #1;
        address  = 32'd1024;
        mem_r_en = 1'b1;
        cyc      = 0;
        while (rd_log.size() < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_fill_hi", 32'(rd_log.size()), 32'd2);
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(ready), 32'd1);
        check_eq("midrst_sram_r_en", 32'(sram_r_en), 32'd0);
        check_eq("midrst_sram_w_en", 32'(sram_w_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_clear();
        clear_logs();
        do_read(32'd1024);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12) do_read(rand_addr());
            else        do_write(rand_addr(), $urandom, r == 19);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
